// File: rtl/stdp_learning_engine.sv
// -----------------------------------------------------------------------------
// stdp_learning_engine
//
// Synaptic learning stage that sits after the RPU controller. Between
// learning passes it tracks pre- and post-synaptic spike traces and
// accumulates a pending STDP weight change for every synapse. An
// enable_learning pulse starts a sweep that visits one synapse per cycle and
// folds its pending change into the stored weight with unsigned saturation.
// learn_done pulses once when the sweep ends and feeds the controller's done
// input.
//
// Optional build macro: STDP_UPDATE_COUNT_EN adds the update_count output,
// the number of synapses whose stored weight changed in the latest sweep.
//
// Ports:
//   clk              clock
//   rst              asynchronous active-high reset
//   pre_spike        per-synapse input spikes (one-cycle pulses)
//   post_spike       output-neuron spike
//   enable_learning  sweep request pulse (ignored while busy)
//   reset_neurons    clears all traces (pending changes are kept)
//   wr_en/wr_addr/wr_data  host weight write, honoured only in IDLE
//   rd_addr/rd_data  registered weight read, 1-cycle latency, 0 out of range
//   learn_busy       high in SWEEP and DONE
//   learn_done       one-cycle pulse in DONE
//   update_count     (STDP_UPDATE_COUNT_EN only) changed-weight count
// -----------------------------------------------------------------------------
module stdp_learning_engine #(
    parameter int N_SYN        = 8,
    parameter int W_WIDTH      = 8,
    parameter int T_WIDTH      = 4,
    parameter int DECAY_PERIOD = 4,
    parameter int LTP_SHIFT    = 1,
    parameter int LTD_SHIFT    = 2,
    parameter int W_INIT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SYN-1:0]           pre_spike,
    input  logic                       post_spike,
    input  logic                       enable_learning,
    input  logic                       reset_neurons,
    input  logic                       wr_en,
    input  logic [$clog2(N_SYN)-1:0]   wr_addr,
    input  logic [W_WIDTH-1:0]         wr_data,
    input  logic [$clog2(N_SYN)-1:0]   rd_addr,
    output logic [W_WIDTH-1:0]         rd_data,
    output logic                       learn_busy,
    output logic                       learn_done
`ifdef STDP_UPDATE_COUNT_EN
    ,
    output logic [$clog2(N_SYN+1)-1:0] update_count
`endif
);

    localparam int A_W   = $clog2(N_SYN);
    localparam int ACC_W = W_WIDTH + 2;
    // Wide enough for acc + ltp - ltd without wrap before saturation.
    localparam int SUM_W = ((ACC_W > T_WIDTH + 1) ? ACC_W : T_WIDTH + 1) + 2;
    // Unsigned weight plus signed pending change.
    localparam int WS_W  = ACC_W + 1;
    localparam int PS_W  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX_S = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN_S = SUM_W'(-(2 ** (ACC_W - 1)));
    localparam logic signed [WS_W-1:0]  W_MAX_S   = WS_W'((2 ** W_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [A_W-1:0]     idx_reg, idx_next;
    logic [PS_W-1:0]    ps_cnt_reg;
    logic               tick;
    logic [T_WIDTH-1:0] post_trace_reg;
    logic               sweep_active;
    logic               wr_ok;

    logic [W_WIDTH-1:0]       w_cur   [N_SYN];
    logic signed [ACC_W-1:0]  acc_cur [N_SYN];

    logic [W_WIDTH-1:0]       cur_w;
    logic signed [ACC_W-1:0]  cur_acc;
    logic signed [WS_W-1:0]   w_sum;
    logic [W_WIDTH-1:0]       w_new;
    logic [W_WIDTH-1:0]       rd_mux;

    // Spike sets the trace to full scale, a decay tick lowers it by one with
    // a floor of zero, and a trace clear beats everything.
    function automatic logic [T_WIDTH-1:0] trace_update(
        input logic [T_WIDTH-1:0] cur,
        input logic               spike,
        input logic               clr,
        input logic               tk
    );
        if (clr)
            return '0;
        else if (spike)
            return '1;
        else if (tk && (cur != '0))
            return cur - T_WIDTH'(1);
        else
            return cur;
    endfunction

    // ------------------------------------------------------------------
    // Decay prescaler
    // ------------------------------------------------------------------
    assign tick = (ps_cnt_reg == PS_W'(DECAY_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ps_cnt_reg <= '0;
        else if (tick)
            ps_cnt_reg <= '0;
        else
            ps_cnt_reg <= ps_cnt_reg + PS_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            post_trace_reg <= '0;
        else
            post_trace_reg <= trace_update(post_trace_reg, post_spike, reset_neurons, tick);
    end

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        learn_busy = 1'b0;
        learn_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable_learning) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                learn_busy = 1'b1;
                if (idx_reg == A_W'(N_SYN - 1)) begin
                    state_next = DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + A_W'(1);
                end
            end
            DONE: begin
                learn_busy = 1'b1;
                learn_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign sweep_active = (state_reg == SWEEP);
    assign wr_ok        = wr_en && (state_reg == IDLE);

    // ------------------------------------------------------------------
    // Weight update for the synapse currently addressed by the sweep
    // ------------------------------------------------------------------
    assign cur_w   = w_cur[idx_reg];
    assign cur_acc = acc_cur[idx_reg];

    always_comb begin
        w_sum = $signed(WS_W'({1'b0, cur_w})) + WS_W'(cur_acc);
        if (w_sum[WS_W-1])
            w_new = '0;
        else if (w_sum > W_MAX_S)
            w_new = '1;
        else
            w_new = w_sum[W_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Per-synapse trace, accumulator and weight
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_SYN; gi++) begin : g_syn
            logic [W_WIDTH-1:0]      w_reg;
            logic signed [ACC_W-1:0] acc_reg, acc_next;
            logic [T_WIDTH-1:0]      pre_trace_reg;
            logic                    sel;
            logic signed [SUM_W-1:0] ltp, ltd, acc_base, acc_sum;

            assign sel = sweep_active && (idx_reg == A_W'(gi));

            // Both terms use the traces as they stand before this edge, so a
            // coincident pre+post pair on idle traces contributes nothing.
            // While this synapse is being swept its old total moves into the
            // weight, so only the current cycle's contribution is kept.
            always_comb begin
                ltp      = post_spike    ? SUM_W'(pre_trace_reg  >> LTP_SHIFT) : '0;
                ltd      = pre_spike[gi] ? SUM_W'(post_trace_reg >> LTD_SHIFT) : '0;
                acc_base = sel ? '0 : SUM_W'(acc_reg);
                acc_sum  = acc_base + ltp - ltd;
                if (acc_sum > ACC_MAX_S)
                    acc_next = ACC_W'(ACC_MAX_S);
                else if (acc_sum < ACC_MIN_S)
                    acc_next = ACC_W'(ACC_MIN_S);
                else
                    acc_next = acc_sum[ACC_W-1:0];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w_reg         <= W_WIDTH'(W_INIT);
                    acc_reg       <= '0;
                    pre_trace_reg <= '0;
                end else begin
                    pre_trace_reg <= trace_update(pre_trace_reg, pre_spike[gi], reset_neurons, tick);
                    acc_reg       <= acc_next;
                    if (sel)
                        w_reg <= w_new;
                    else if (wr_ok && (wr_addr == A_W'(gi)))
                        w_reg <= wr_data;
                end
            end

            assign w_cur[gi]   = w_reg;
            assign acc_cur[gi] = acc_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered read port; unmatched addresses read as zero
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (rd_addr == A_W'(i))
                rd_mux = w_cur[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= rd_mux;
    end

`ifdef STDP_UPDATE_COUNT_EN
    localparam int UC_W = $clog2(N_SYN + 1);

    logic w_changed;
    assign w_changed = (w_new != cur_w);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            update_count <= '0;
        else if ((state_reg == IDLE) && enable_learning)
            update_count <= '0;
        else if (sweep_active && w_changed)
            update_count <= update_count + UC_W'(1);
    end
`endif

endmodule
